alu_share_arbiter: RTL and testbench

- Shares one ArithmeticLogicUnit instance between two requesters, for example the instruction sequencer and an address/DMA engine.
- Runs round-robin arbitration and latches the granted operands.
- Drives the ALU for exactly one execute cycle, then returns the registered result and updated flags with a single-cycle Ack.
- Keeps the ALU flag register from being written outside a granted execute cycle.

---
 rtl/alu_share_arbiter_if.sv | 57 +++++
 rtl/alu_share_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Bundle between the two ALU requesters, the shared ALU and the arbiter.
// Optional build macro: ALU_ARB_LOCK_EN adds lock0/lock1 ownership-lock inputs.
// Modports:
//   master - requesters and ALU (drive requests, operands, ALU result/flags)
//   slave  - alu_share_arbiter (drives acks, result, busy, grant, ALU controls)
interface alu_share_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FS_WIDTH   = 5,
   parameter int unsigned FLAG_WIDTH = 4
);
   logic                  req0;
   logic                  req1;
   logic [FS_WIDTH-1:0]   fun_sel0;
   logic [FS_WIDTH-1:0]   fun_sel1;
   logic [DATA_WIDTH-1:0] a0;
   logic [DATA_WIDTH-1:0] a1;
   logic [DATA_WIDTH-1:0] b0;
   logic [DATA_WIDTH-1:0] b1;
   logic                  wf0;
   logic                  wf1;
`ifdef ALU_ARB_LOCK_EN
   logic                  lock0;
   logic                  lock1;
`endif
   logic                  ack0;
   logic                  ack1;
   logic [DATA_WIDTH-1:0] result;
   logic [FLAG_WIDTH-1:0] flags_res;
   logic                  busy;
   logic                  grant;
   logic [DATA_WIDTH-1:0] alu_a;
   logic [DATA_WIDTH-1:0] alu_b;
   logic [FS_WIDTH-1:0]   alu_fun_sel;
   logic                  alu_wf;
   logic [DATA_WIDTH-1:0] alu_out;
   logic [FLAG_WIDTH-1:0] alu_flags;

   modport master (
      output req0, req1, fun_sel0, fun_sel1, a0, a1, b0, b1, wf0, wf1,
`ifdef ALU_ARB_LOCK_EN
      output lock0, lock1,
`endif
      output alu_out, alu_flags,
      input  ack0, ack1, result, flags_res, busy, grant,
      input  alu_a, alu_b, alu_fun_sel, alu_wf
   );

   modport slave (
      input  req0, req1, fun_sel0, fun_sel1, a0, a1, b0, b1, wf0, wf1,
`ifdef ALU_ARB_LOCK_EN
      input  lock0, lock1,
`endif
      input  alu_out, alu_flags,
      output ack0, ack1, result, flags_res, busy, grant,
      output alu_a, alu_b, alu_fun_sel, alu_wf
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// A grant latches the winner's operands, drives the ALU for exactly one
// execute cycle (the only cycle alu_wf may be high), then pulses the
// winner's ack with the registered result and the fresh ALU flags.
// Optional build macro: ALU_ARB_LOCK_EN (owner lock for multi-word chains).
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_share_arbiter_if.slave (requests, acks, result, ALU side)
module alu_share_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FS_WIDTH   = 5,
   parameter int unsigned FLAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_share_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  fav_q, fav_d;
   logic                  grant_q, grant_d;
   logic [FS_WIDTH-1:0]   fs_q, fs_d;
   logic [DATA_WIDTH-1:0] opa_q, opa_d;
   logic [DATA_WIDTH-1:0] opb_q, opb_d;
   logic                  alu_wf_q, alu_wf_d;
   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic                  busy_q, busy_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [FLAG_WIDTH-1:0] flags_res_q, flags_res_d;
   logic                  elig0, elig1, win;
`ifdef ALU_ARB_LOCK_EN
   logic                  lock_q, lock_d;
   logic                  own_lock;
   assign own_lock = grant_q ? bus.lock1 : bus.lock0;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         fav_q       <= 1'b0;
         grant_q     <= 1'b0;
         fs_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         alu_wf_q    <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         busy_q      <= 1'b0;
         result_q    <= '0;
         flags_res_q <= '0;
`ifdef ALU_ARB_LOCK_EN
         lock_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         fav_q       <= fav_d;
         grant_q     <= grant_d;
         fs_q        <= fs_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         alu_wf_q    <= alu_wf_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         busy_q      <= busy_d;
         result_q    <= result_d;
         flags_res_q <= flags_res_d;
`ifdef ALU_ARB_LOCK_EN
         lock_q      <= lock_d;
`endif
      end
   end

   // Next-state, arbitration and output register updates
   always_comb begin
      state_d     = state_q;
      fav_d       = fav_q;
      grant_d     = grant_q;
      fs_d        = fs_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      alu_wf_d    = 1'b0;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      busy_d      = 1'b0;
      result_d    = result_q;
      flags_res_d = flags_res_q;
      elig0       = bus.req0;
      elig1       = bus.req1;
      win         = 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_d      = lock_q;
`endif

      case (state_q)
         IDLE: begin
`ifdef ALU_ARB_LOCK_EN
            // Locked owner keeps the ALU; release falls through to round-robin
            if (lock_q) begin
               if (own_lock) begin
                  elig0 = bus.req0 & ~grant_q;
                  elig1 = bus.req1 &  grant_q;
               end else begin
                  lock_d = 1'b0;
               end
            end
`endif
            if (elig0 || elig1) begin
               win      = (elig0 && elig1) ? fav_q : elig1;
               grant_d  = win;
               fs_d     = win ? bus.fun_sel1 : bus.fun_sel0;
               opa_d    = win ? bus.a1 : bus.a0;
               opb_d    = win ? bus.b1 : bus.b0;
               alu_wf_d = win ? bus.wf1 : bus.wf0;
               busy_d   = 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            result_d = bus.alu_out;
            ack0_d   = ~grant_q;
            ack1_d   = grant_q;
            busy_d   = 1'b1;
            state_d  = CAPTURE;
         end
         CAPTURE: begin
            flags_res_d = bus.alu_flags;
            fav_d       = ~grant_q;
`ifdef ALU_ARB_LOCK_EN
            lock_d      = lock_q | own_lock;
`endif
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ack0        = ack0_q;
   assign bus.ack1        = ack1_q;
   assign bus.busy        = busy_q;
   assign bus.grant       = grant_q;
   assign bus.result      = result_q;
   assign bus.alu_a       = opa_q;
   assign bus.alu_b       = opb_q;
   assign bus.alu_fun_sel = fs_q;
   assign bus.alu_wf      = alu_wf_q;
   // Flags written at the ISSUE edge are visible on the ALU during CAPTURE,
   // so they bypass the register to line up with ack.
   assign bus.flags_res   = (state_q == CAPTURE) ? bus.alu_flags : flags_res_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
   localparam int unsigned DW = 32;
   localparam int unsigned FW = 5;
   localparam int unsigned GW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.DATA_WIDTH(DW), .FS_WIDTH(FW), .FLAG_WIDTH(GW)) bus ();

   alu_share_arbiter #(.DATA_WIDTH(DW), .FS_WIDTH(FW), .FLAG_WIDTH(GW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int both_ack = 0;
   int wf_bad = 0;

   // Reference ALU: flags {Z,C,N,O}, written only when alu_wf is high
   logic [GW-1:0] alu_flags_r = '0;
   logic [32:0]   ext;
   logic [31:0]   res;
   logic [3:0]    nf;
   always_comb begin
      ext = '0;
      case (bus.alu_fun_sel)
         5'b10100: ext = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         5'b10101: ext = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 33'(alu_flags_r[2]);
         5'b10110: ext = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
         5'b10111: ext = {1'b0, bus.alu_a & bus.alu_b};
         default:  ext = {1'b0, bus.alu_a};
      endcase
      res = ext[31:0];
      nf  = {res == 32'd0, ext[32], res[31],
             (bus.alu_a[31] == bus.alu_b[31]) && (res[31] != bus.alu_a[31])};
      bus.alu_out   = res;
      bus.alu_flags = alu_flags_r;
   end
   always @(posedge clk) if (bus.alu_wf) alu_flags_r <= nf;

   always @(negedge clk) begin
      if (bus.ack0 && bus.ack1) both_ack++;
      if (bus.alu_wf && (!bus.busy || bus.ack0 || bus.ack1)) wf_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_any(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(bus.ack0 || bus.ack1) && cyc < 12);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ack0"},  32'(bus.ack0), 32'd0);
      chk({tag, "_ack1"},  32'(bus.ack1), 32'd0);
      chk({tag, "_busy"},  32'(bus.busy), 32'd0);
      chk({tag, "_wf"},    32'(bus.alu_wf), 32'd0);
      chk({tag, "_grant"}, 32'(bus.grant), 32'd0);
      chk({tag, "_res"},   bus.result, 32'd0);
      chk({tag, "_flags"}, 32'(bus.flags_res), 32'd0);
      chk({tag, "_alua"},  bus.alu_a, 32'd0);
      chk({tag, "_alub"},  bus.alu_b, 32'd0);
      chk({tag, "_fs"},    32'(bus.alu_fun_sel), 32'd0);
   endtask

   // Issue one op from an idle cycle, check ack timing, result and flags
   task automatic run_op(input string tag, input bit idx, input logic [4:0] fs,
                         input logic [31:0] a, input logic [31:0] b, input logic wf,
                         input logic [31:0] exp_res, input logic [3:0] exp_flags);
      int cyc;
      if (idx) begin
         bus.req1 = 1'b1; bus.fun_sel1 = fs; bus.a1 = a; bus.b1 = b; bus.wf1 = wf;
      end else begin
         bus.req0 = 1'b1; bus.fun_sel0 = fs; bus.a0 = a; bus.b0 = b; bus.wf0 = wf;
      end
      wait_any(cyc);
      chk({tag, "_lat"},   32'(cyc), 32'd2);
      chk({tag, "_ack0"},  32'(bus.ack0), 32'(!idx));
      chk({tag, "_ack1"},  32'(bus.ack1), 32'(idx));
      chk({tag, "_grant"}, 32'(bus.grant), 32'(idx));
      chk({tag, "_res"},   bus.result, exp_res);
      chk({tag, "_flags"}, 32'(bus.flags_res), 32'(exp_flags));
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
      chk({tag, "_ackdrop"},   32'(bus.ack0 | bus.ack1), 32'd0);
      chk({tag, "_reshold"},   bus.result, exp_res);
      chk({tag, "_flagshold"}, 32'(bus.flags_res), 32'(exp_flags));
   endtask

   initial begin
      int cyc;
      int acks;
      bit exp_idx;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.fun_sel0 = '0; bus.fun_sel1 = '0;
      bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
      bus.wf0 = 1'b0; bus.wf1 = 1'b0;
`ifdef ALU_ARB_LOCK_EN
      bus.lock0 = 1'b0; bus.lock1 = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk_all_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Contention: both held, grants alternate 0,1,0,1 three cycles apart
      bus.req0 = 1'b1; bus.fun_sel0 = 5'b10100; bus.a0 = 32'd1;  bus.b0 = 32'd2; bus.wf0 = 1'b0;
      bus.req1 = 1'b1; bus.fun_sel1 = 5'b10110; bus.a1 = 32'd10; bus.b1 = 32'd4; bus.wf1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_idx = i[0];
         wait_any(cyc);
         chk("cont_gap",   32'(cyc), (i == 0) ? 32'd2 : 32'd3);
         chk("cont_ack0",  32'(bus.ack0), 32'(!exp_idx));
         chk("cont_ack1",  32'(bus.ack1), 32'(exp_idx));
         chk("cont_grant", 32'(bus.grant), 32'(exp_idx));
         chk("cont_res",   bus.result, exp_idx ? 32'd6 : 32'd3);
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      @(negedge clk);

      // Single ADD wrapping to zero sets Z and C
      run_op("add", 1'b0, 5'b10100, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 4'b1100);

      // AND with WF=0 must leave C=1 untouched
      bus.req1 = 1'b1; bus.fun_sel1 = 5'b10111; bus.a1 = 32'hF0F0_F0F0;
      bus.b1 = 32'hFF00_FF00; bus.wf1 = 1'b0;
      @(negedge clk);
      chk("fp_wf_issue", 32'(bus.alu_wf), 32'd0);
      chk("fp_busy",     32'(bus.busy), 32'd1);
      @(negedge clk);
      chk("fp_ack1",  32'(bus.ack1), 32'd1);
      chk("fp_res",   bus.result, 32'hF000_F000);
      chk("fp_flags", 32'(bus.flags_res), 32'hC);
      bus.req1 = 1'b0;
      @(negedge clk);

      // Operand change after grant is ignored
      bus.req1 = 1'b1; bus.fun_sel1 = 5'b10110; bus.a1 = 32'd5; bus.b1 = 32'd3; bus.wf1 = 1'b0;
      @(negedge clk);
      chk("lat_alua", bus.alu_a, 32'd5);
      bus.a1 = 32'd9;
      @(negedge clk);
      chk("lat_ack1", 32'(bus.ack1), 32'd1);
      chk("lat_res",  bus.result, 32'd2);
      bus.req1 = 1'b0;
      @(negedge clk);

      // Reset during ISSUE drops the op; the ALU flags are not written
      bus.req0 = 1'b1; bus.fun_sel0 = 5'b10100; bus.a0 = 32'd7; bus.b0 = 32'd8; bus.wf0 = 1'b1;
      @(negedge clk);
      chk("rmid_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rmid");
      bus.req0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.ack0 || bus.ack1) acks++;
      end
      chk("rmid_noack", 32'(acks), 32'd0);
      run_op("rmid_req1", 1'b1, 5'b10110, 32'd20, 32'd8, 1'b0, 32'd12, 4'b1100);

`ifdef ALU_ARB_LOCK_EN
      // Lock0 keeps two req0 ops back to back while req1 waits
      bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.fun_sel0 = 5'b10100;
      bus.a0 = 32'hFFFF_FFFF; bus.b0 = 32'd1; bus.wf0 = 1'b1;
      bus.req1 = 1'b1; bus.lock1 = 1'b0; bus.fun_sel1 = 5'b10100;
      bus.a1 = 32'd2; bus.b1 = 32'd3; bus.wf1 = 1'b0;
      wait_any(cyc);
      chk("lk_add_ack0",  32'(bus.ack0), 32'd1);
      chk("lk_add_res",   bus.result, 32'd0);
      chk("lk_add_flags", 32'(bus.flags_res), 32'hC);
      bus.fun_sel0 = 5'b10101; bus.a0 = 32'd0; bus.b0 = 32'd0;
      @(negedge clk);
      @(negedge clk);
      chk("lk_adc_grant", 32'(bus.grant), 32'd0);
      bus.lock0 = 1'b0;
      wait_any(cyc);
      chk("lk_adc_ack0",  32'(bus.ack0), 32'd1);
      chk("lk_adc_res",   bus.result, 32'd1);
      chk("lk_adc_flags", 32'(bus.flags_res), 32'd0);
      bus.req0 = 1'b0;
      wait_any(cyc);
      chk("lk_r1_ack1", 32'(bus.ack1), 32'd1);
      chk("lk_r1_res",  bus.result, 32'd5);
      bus.req1 = 1'b0;
      @(negedge clk);
`endif

      chk("ack_exclusive", 32'(both_ack), 32'd0);
      chk("wf_only_issue", 32'(wf_bad), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
